// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// No logic, no latency.
// No flow control of its own.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int          WORD_BYTES = 8;
  localparam logic [7:0]  STRB_READ  = 8'h00;

endpackage

// File: rtl/dmem_sram.sv
// Single-port 64-bit byte-writable array; contents are never reset.
// Latency: write commits at the clock edge, read is combinational.
// Backpressure: none, one access per cycle.
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem_q [DEPTH_WORDS];

  // Byte-lane write: only lanes with a set enable are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read returns the word as it was before any write on this edge.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the load/store data interface, one request in flight.
// Latency: bvalid rises LATENCY+1 cycles after acceptance; one request per LATENCY+2 cycles.
// Backpressure: bvalid/rdata/berr held while bready is low; aready only in IDLE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              avalid,
  output logic              aready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  output logic [63:0]       rdata,
  output logic              bvalid,
  input  logic              bready,
  output logic              berr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int AW1   = ADDR_W + 1;
  // Span is compared one bit wider so a full-address-space span still works.
  localparam logic [ADDR_W:0]   SPAN = AW1'(WORD_BYTES * DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              berr_q, berr_d;

  logic [ADDR_W-1:0] off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              mem_we;
  logic [63:0]       mem_rdata;

  // Address below base wraps to a large offset and fails the span check.
  always_comb begin
    off      = addr - BASE;
    in_range = ({1'b0, off} < SPAN);
    idx      = off[IDX_W+2:3];
    aready   = (state_q == IDLE) && !rst;
    accept   = avalid && aready;
    mem_we   = accept && in_range && (wstrb != STRB_READ);
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .be    (wstrb),
    .addr  (idx),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  // Next-state: capture response at acceptance, count down, then hold until bready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = in_range ? mem_rdata : 64'h0;
          berr_d  = !in_range;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 64'h0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign bvalid = (state_q == RESP);
  assign rdata  = rdata_q;
  assign berr   = berr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
// Inputs driven at negedge, outputs sampled at negedge.
// Expected responses queued at acceptance and popped at the handshake.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [63:0] wdata = 64'h0;
  logic [7:0]  wstrb = 8'h0;
  logic        bready = 1'b0;
  logic        avalid2 = 1'b0, avalid0 = 1'b0;

  logic        aready2, bvalid2, berr2;
  logic [63:0] rdata2;
  logic        aready0, bvalid0, berr0;
  logic [63:0] rdata0;

  bit          sel = 1'b0;   // 0: LATENCY=2 instance, 1: LATENCY=0 instance
  logic        cur_aready, cur_bvalid, cur_berr;
  logic [63:0] cur_rdata;

  int cyc = 0;
  int pass_cnt = 0;
  int tot_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    int          bp;
    logic [63:0] exp_rd;
    logic        exp_berr;
    bit          chk_rd;
  } rec_t;

  typedef struct {
    logic [63:0] rd;
    logic        berr;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  rec_t tbl[14];
  rec_t tbl0[2];

  dmem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .avalid(avalid2), .aready(aready2),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata2), .bvalid(bvalid2),
    .bready(bready), .berr(berr2)
  );

  dmem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .addr(addr), .avalid(avalid0), .aready(aready0),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata0), .bvalid(bvalid0),
    .bready(bready), .berr(berr0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cur_aready = sel ? aready0 : aready2;
    cur_bvalid = sel ? bvalid0 : bvalid2;
    cur_berr   = sel ? berr0   : berr2;
    cur_rdata  = sel ? rdata0  : rdata2;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout act=%0d cycles req=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s act=%h req=%h", name, act, exp);
  endtask

  task automatic set_av(input logic v);
    avalid2 = (!sel) ? v : 1'b0;
    avalid0 = sel ? v : 1'b0;
  endtask

  function automatic rec_t mk(input logic [31:0] a, input logic [7:0] s, input logic [63:0] w,
                              input int bp, input logic [63:0] e, input logic eb, input bit c);
    rec_t r;
    r.addr = a; r.strb = s; r.wdata = w; r.bp = bp;
    r.exp_rd = e; r.exp_berr = eb; r.chk_rd = c;
    return r;
  endfunction

  // One full request: accept, check latency, optional backpressure, handshake.
  task automatic xact(input bit sel_i, input rec_t r);
    int   lat, n, acc;
    exp_t e;
    lat = sel_i ? 0 : 2;
    @(negedge clk);
    sel = sel_i; addr = r.addr; wstrb = r.strb; wdata = r.wdata; bready = 1'b0;
    set_av(1'b1);
    #1;
    n = 0;
    while (!cur_aready && n < 20) begin @(negedge clk); n++; end
    chk("accept", 64'(cur_aready), 64'd1);
    e.rd = r.exp_rd; e.berr = r.exp_berr; e.chk_rd = r.chk_rd;
    sb.push_back(e);
    acc = cyc;
    @(negedge clk);
    set_av(1'b0);
    n = 0;
    while (!cur_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 64'(cyc - acc), 64'(lat + 1));
    for (int i = 0; i < r.bp; i++) begin
      chk("bp_bvalid", 64'(cur_bvalid), 64'd1);
      chk("bp_aready", 64'(cur_aready), 64'd0);
      chk("bp_berr", 64'(cur_berr), 64'(r.exp_berr));
      if (r.chk_rd) chk("bp_rdata", cur_rdata, r.exp_rd);
      @(negedge clk);
    end
    bready = 1'b1;
    chk("hs_bvalid", 64'(cur_bvalid), 64'd1);
    chk("hs_aready", 64'(cur_aready), 64'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("berr", 64'(cur_berr), 64'(e.berr));
      if (e.chk_rd) chk("rdata", cur_rdata, e.rd);
    end
    @(negedge clk);
    bready = 1'b0;
    chk("post_bvalid", 64'(cur_bvalid), 64'd0);
    chk("post_aready", 64'(cur_aready), 64'd1);
    chk("post_berr_hold", 64'(cur_berr), 64'(e.berr));
    if (e.chk_rd) chk("post_rdata_hold", cur_rdata, e.rd);
  endtask

  // avalid and bready held high: measures throughput and bvalid pulse width.
  task automatic stream(input bit sel_i);
    int lat, n, nacc, first_bv, bvcnt;
    int acc[3];
    lat = sel_i ? 0 : 2;
    nacc = 0; first_bv = -1; bvcnt = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    @(negedge clk);
    sel = sel_i; addr = 32'h8000_0010; wstrb = 8'h00; bready = 1'b1;
    set_av(1'b1);
    #1;
    for (n = 0; n < 60 && nacc < 3; n++) begin
      if (cur_bvalid) begin
        chk("stream_aready_in_resp", 64'(cur_aready), 64'd0);
        if (first_bv < 0) first_bv = cyc;
        if (nacc == 1) bvcnt++;
      end
      if (cur_aready) begin
        acc[nacc] = cyc;
        nacc++;
      end
      if (nacc < 3) @(negedge clk);
    end
    @(negedge clk);
    set_av(1'b0);
    n = 0;
    while (!(cur_aready && !cur_bvalid) && n < 20) begin @(negedge clk); n++; end
    bready = 1'b0;
    chk("stream_acc_count", 64'(nacc), 64'd3);
    chk("stream_first_latency", 64'(first_bv - acc[0]), 64'(lat + 1));
    chk("stream_interval1", 64'(acc[1] - acc[0]), 64'(lat + 2));
    chk("stream_interval2", 64'(acc[2] - acc[1]), 64'(lat + 2));
    chk("stream_bvalid_width", 64'(bvcnt), 64'd1);
  endtask

  initial begin
    tbl[0]  = mk(32'h8000_0000, 8'hFF, 64'hCAFE_F00D_1234_5678, 0, 64'h0, 1'b0, 1'b0);
    tbl[1]  = mk(32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0, 1'b0, 1'b0);
    tbl[2]  = mk(32'h8000_0010, 8'h00, 64'h0, 0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
    tbl[3]  = mk(32'h8000_0010, 8'h0C, 64'h0000_0000_AABB_0000, 0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
    tbl[4]  = mk(32'h8000_0010, 8'h00, 64'h0, 5, 64'h1122_3344_AABB_7788, 1'b0, 1'b1);
    tbl[5]  = mk(32'h8000_0017, 8'h00, 64'h0, 0, 64'h1122_3344_AABB_7788, 1'b0, 1'b1);
    tbl[6]  = mk(32'h7FFF_FFF8, 8'h00, 64'h0, 2, 64'h0, 1'b1, 1'b1);
    tbl[7]  = mk(32'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 1'b1, 1'b1);
    tbl[8]  = mk(32'h8000_0000, 8'h00, 64'h0, 0, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b1);
    tbl[9]  = mk(32'h8000_7FF8, 8'hFF, 64'h0102_0304_0506_0708, 0, 64'h0, 1'b0, 1'b0);
    tbl[10] = mk(32'h8000_7FF8, 8'h00, 64'h0, 0, 64'h0102_0304_0506_0708, 1'b0, 1'b1);
    tbl[11] = mk(32'h8000_7FF8, 8'h01, 64'h0000_0000_0000_00FF, 0, 64'h0102_0304_0506_0708, 1'b0, 1'b1);
    tbl[12] = mk(32'h8000_7FF8, 8'h00, 64'h0, 0, 64'h0102_0304_0506_07FF, 1'b0, 1'b1);
    tbl[13] = mk(32'hFFFF_FFF8, 8'h00, 64'h0, 0, 64'h0, 1'b1, 1'b1);
    tbl0[0] = mk(32'h8000_0008, 8'hFF, 64'h5555_6666_7777_8888, 0, 64'h0, 1'b0, 1'b0);
    tbl0[1] = mk(32'h8000_0008, 8'h00, 64'h0, 2, 64'h5555_6666_7777_8888, 1'b0, 1'b1);

    // Reset held three cycles with requests pending on both instances.
    rst = 1'b1; avalid2 = 1'b1; avalid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_aready", 64'(aready2), 64'd0);
      chk("rst_bvalid", 64'(bvalid2), 64'd0);
      chk("rst_rdata", rdata2, 64'h0);
      chk("rst_aready0", 64'(aready0), 64'd0);
      chk("rst_bvalid0", 64'(bvalid0), 64'd0);
    end
    rst = 1'b0; avalid2 = 1'b0; avalid0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_aready", 64'(aready2), 64'd1);
      chk("idle_bvalid", 64'(bvalid2), 64'd0);
      chk("idle_aready0", 64'(aready0), 64'd1);
      chk("idle_bvalid0", 64'(bvalid0), 64'd0);
    end

    for (int i = 0; i < 14; i++) xact(1'b0, tbl[i]);
    for (int i = 0; i < 2; i++) xact(1'b1, tbl0[i]);

    stream(1'b0);
    stream(1'b1);

    // Reset while the LATENCY=2 instance is waiting: the request is dropped.
    @(negedge clk);
    sel = 1'b0; addr = 32'h8000_0010; wstrb = 8'h00; bready = 1'b1;
    set_av(1'b1);
    #1;
    chk("wait_rst_accept", 64'(aready2), 64'd1);
    @(negedge clk);
    set_av(1'b0);
    chk("wait_rst_in_wait", 64'(bvalid2), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("wait_rst_aready", 64'(aready2), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait_rst_no_bvalid", 64'(bvalid2), 64'd0);
    end
    chk("wait_rst_idle", 64'(aready2), 64'd1);
    chk("wait_rst_rdata", rdata2, 64'h0);
    bready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
